seq_detect_cfg: RTL
===================

// Module: seq_detect_cfg
// PURPOSE
//   Parametrised serial pattern detector, successor to the fixed-pattern single-bit detector.
//   Samples a 1-bit stream qualified by din_vld and matches the last PAT_W valid bits against a
//   runtime-programmable pattern with a per-bit don't-care mask. Supports overlap and non-overlap modes.
//   Pulses result on each match and keeps a saturating match counter.
//   Sits between the serial front end and the control/status logic.
// PARAMETERS
//   PAT_W        8          pattern length in bits (2..32)
//   CNT_W        8          match counter width (>=1)
//   DEFAULT_PAT  8'hB2      pattern loaded at reset, PAT_W bits wide
// PORTS
//   clk          in   1      system clock, rising edge
//   rst_n        in   1      asynchronous active-low reset
//   din          in   1      serial data bit
//   din_vld      in   1      din is valid this cycle
//   clr          in   1      synchronous clear of history, fill count, result and match_cnt
//   cfg_we       in   1      load cfg_pat, cfg_mask and cfg_overlap this cycle
//   cfg_pat      in   PAT_W  pattern; MSB is compared with the oldest bit
//   cfg_mask     in   PAT_W  1 = bit compared, 0 = don't care
//   cfg_overlap  in   1      1 = overlapping matches allowed
//   result       out  1      one-cycle match pulse (registered)
//   match_cnt    out  CNT_W  number of matches since reset/clr, saturating
// BEHAVIOUR
//   Reset (async, rst_n=0): hist=0, fill=0, result=0, match_cnt=0, pat=DEFAULT_PAT, mask=all 1s, overlap=1.
//   Shift: on an edge with din_vld=1 (and no clr or cfg_we), hist <= {hist[PAT_W-2:0], din}.
//     fill <= min(fill+1, PAT_W). The first-received bit ends at hist[PAT_W-1].
//   Match: nxt_hist is the shifted value. It matches when nxt_fill==PAT_W and ((nxt_hist ^ pat) & mask)==0.
//     result is 1 for exactly the cycle after the edge that sampled the last pattern bit.
//     result is 0 at every other time, including any cycle following din_vld=0.
//     Latency: 1 clock from the sampling edge.
//   Overlap=1: hist and fill are kept after a match, so the next match can complete on any later valid bit.
//   Overlap=0: fill <= 0 on a match, so PAT_W fresh valid bits are needed before the next match.
//   match_cnt: incremented on each match edge; holds at 2^CNT_W-1.
//   din_vld=0: hist, fill and match_cnt hold. Gaps of any length between valid bits are transparent.
//   cfg_we=1: pat, mask and overlap are loaded. fill <= 0, result <= 0, and din on that edge is discarded.
//     match_cnt is not affected.
//   clr=1: hist <= 0, fill <= 0, result <= 0, match_cnt <= 0, and din on that edge is discarded.
//     If cfg_we is also 1 on the same edge, the configuration still loads.
//   Priority on one edge: clr > cfg_we > din_vld shift.
//   mask=0: every valid bit matches once fill==PAT_W (overlap=1), or every PAT_W bits (overlap=0). This is legal.
//   Reset mid-stream discards all partial history. No match can fire before PAT_W new valid bits.
//   All state is in flops. No combinational path from din or din_vld to result.
// TESTING
//   1 Default cfg, stream 1,0,1,1,0,0,1,0 with din_vld=1
//     -> result=1 only in the cycle after the 8th bit; match_cnt=1.
//   2 cfg pat=8'hAA, mask=8'hFF, overlap=1, stream 1010101010 -> pulses after bits 8 and 10; match_cnt=2.
//     Repeat with overlap=0 -> single pulse after bit 8; match_cnt=1.
//   3 Default cfg, stream 1011 then din_vld=0 for 3 cycles then 0010
//     -> no pulse during the gap; one pulse after the final bit.
//   4 pat=8'hF0, mask=8'hF0: stream 11110101 -> 1 pulse.
//     Then after clr, stream 11100000 -> no pulse; match_cnt=0.
//   5 Default cfg, send 10110, assert rst_n=0 for 1 cycle, send 010
//     -> no pulse; then full 10110010 -> 1 pulse; match_cnt=1.
//   6 CNT_W=2, pat=8'hFF, mask=8'hFF, overlap=1, 12 ones -> 5 pulses; match_cnt saturates at 3.
//     cfg_we during the stream -> fill restarts and match_cnt is held.

Source files
------------

// File: rtl/seq_detect_cfg.sv
// -----------------------------------------------------------------------------
// seq_detect_cfg
//   Serial pattern detector with a runtime-programmable pattern and per-bit
//   don't-care mask. The last PAT_W qualified bits of a 1-bit stream are
//   compared against the pattern. The oldest bit is compared with the pattern
//   MSB. Every match produces a one-cycle registered pulse and advances a
//   saturating match counter. Matches may overlap, or the detector may restart
//   its fill after every match.
//
// Parameters
//   PAT_W        pattern length in bits (2..32)
//   CNT_W        match counter width (>= 1)
//   DEFAULT_PAT  pattern loaded at reset
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   din          serial data bit
//   din_vld      din is valid this cycle
//   clr          synchronous clear of history, fill, result and match_cnt
//   cfg_we       load cfg_pat / cfg_mask / cfg_overlap this cycle
//   cfg_pat      pattern; MSB is compared with the oldest bit
//   cfg_mask     1 = bit compared, 0 = don't care
//   cfg_overlap  1 = overlapping matches allowed
//   result       one-cycle match pulse, one clock after the sampling edge
//   match_cnt    saturating number of matches since reset/clr
// -----------------------------------------------------------------------------
module seq_detect_cfg #(
    parameter int               PAT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 'hB2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_vld,
    input  logic             clr,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_overlap,
    output logic             result,
    output logic [CNT_W-1:0] match_cnt
);

    // Fill counter has to represent 0..PAT_W inclusive.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PAT_W-1:0]  hist_q,      hist_d;
    logic [FILL_W-1:0] fill_q,      fill_d;
    logic              result_q,    result_d;
    logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
    logic [PAT_W-1:0]  pat_q,       pat_d;
    logic [PAT_W-1:0]  mask_q,      mask_d;
    logic              overlap_q,   overlap_d;

    // -------------------------------------------------------------------------
    // Candidate next history and the match test against it. The compare is
    // done on the shifted value so the pulse is registered in the same edge
    // that samples the last pattern bit.
    // -------------------------------------------------------------------------
    logic [PAT_W-1:0]  nxt_hist;
    logic [FILL_W-1:0] nxt_fill;
    logic [PAT_W-1:0]  bit_miss;
    logic              full_next;
    logic              pat_hit;

    assign nxt_hist  = {hist_q[PAT_W-2:0], din};
    assign nxt_fill  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);
    assign full_next = (nxt_fill == FILL_FULL);

    // Per-bit miss: a bit only counts against the match when it is compared.
    genvar gi;
    generate
        for (gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_miss[gi] = (nxt_hist[gi] ^ pat_q[gi]) & mask_q[gi];
        end
    endgenerate

    assign pat_hit = full_next && (bit_miss == '0);

    // -------------------------------------------------------------------------
    // Next-state logic. Priority: clr > cfg_we > din_vld shift.
    // -------------------------------------------------------------------------
    always_comb begin
        hist_d      = hist_q;
        fill_d      = fill_q;
        result_d    = 1'b0;
        match_cnt_d = match_cnt_q;
        pat_d       = pat_q;
        mask_d      = mask_q;
        overlap_d   = overlap_q;

        // Configuration loads whenever requested, even alongside clr.
        if (cfg_we) begin
            pat_d     = cfg_pat;
            mask_d    = cfg_mask;
            overlap_d = cfg_overlap;
        end

        if (clr) begin
            hist_d      = '0;
            fill_d      = '0;
            match_cnt_d = '0;
        end else if (cfg_we) begin
            // New pattern: restart the fill so no match can mix bits that
            // were received under the old configuration. The counter is kept.
            fill_d = '0;
        end else if (din_vld) begin
            hist_d = nxt_hist;
            if (pat_hit) begin
                result_d = 1'b1;
                if (match_cnt_q != CNT_MAX) begin
                    match_cnt_d = match_cnt_q + CNT_W'(1);
                end
                // Non-overlap mode demands PAT_W fresh bits for the next match.
                fill_d = overlap_q ? nxt_fill : '0;
            end else begin
                fill_d = nxt_fill;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q      <= '0;
            fill_q      <= '0;
            result_q    <= 1'b0;
            match_cnt_q <= '0;
            pat_q       <= DEFAULT_PAT;
            mask_q      <= {PAT_W{1'b1}};
            overlap_q   <= 1'b1;
        end else begin
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            result_q    <= result_d;
            match_cnt_q <= match_cnt_d;
            pat_q       <= pat_d;
            mask_q      <= mask_d;
            overlap_q   <= overlap_d;
        end
    end

    assign result    = result_q;
    assign match_cnt = match_cnt_q;

endmodule
